rcc_sched: RTL and testbench
============================

# rcc_sched

Scheduler that shares one WIDTH-bit interval counter among NREQ requesters. It arbitrates pending requests, loads the winner's terminal count, and runs the counter synchronously on `clk` until it reaches that count. It then returns a one-cycle completion pulse to the owner. It sits beside the counter datapath and drives its clear/enable sequencing, so the requesters never touch the counter directly.

## Interface
Parameters:
- `NREQ`, 2: number of requesters (≥2).
- `WIDTH`, 4: counter and length width.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  NREQ  level request per requester; must be held until `done[i]` or abort.
- `len`  in  NREQ*WIDTH  terminal count; slice `[i*WIDTH +: WIDTH]` belongs to requester i; sampled only at grant.
- `abort`  in  1  cancels the running interval.
- `gnt`  out  NREQ  one-hot owner while the counter runs; all-zero otherwise.
- `done`  out  NREQ  one-cycle pulse to the owner on completion.
- `busy`  out  1  high in RUN and DONE.
- `cnt`  out  WIDTH  current counter value.

## Operation
- All outputs are registered. Reset values: `gnt`=0, `done`=0, `busy`=0, `cnt`=0, state=IDLE, RR pointer=0 (requester 0 highest).
- The state machine has three states: IDLE, RUN and DONE.
- **IDLE**
  - If any `req` bit is set, pick the winner i by round-robin starting at the pointer.
  - Load `term` ← `len` slice i, `cnt` ← 0, `gnt` ← one-hot i, then go to RUN.
  - Set the pointer ← i+1, wrapping to 0 at NREQ.
- **RUN**
  - If `abort`: go to IDLE, `gnt` ← 0, `cnt` ← 0, no `done` pulse. Abort wins over a simultaneous `cnt`==`term`.
  - Else if `cnt`==`term`: go to DONE, `gnt` ← 0, `done[i]` ← 1.
  - Else: `cnt` ← `cnt`+1.
- **DONE**
  - `done` ← 0, `cnt` holds its final value, then go to IDLE.
- Arithmetic rules:
  - `cnt` is unsigned and WIDTH bits wide.
  - `cnt` never wraps, because it stops at `term` ≤ 2^WIDTH−1.
  - `len`=0 is legal and gives exactly one RUN cycle.
- Ignored events:
  - `req` changes during RUN or DONE are ignored for the current interval.
  - A requester that drops `req` mid-run still receives `done`.
  - `abort` outside RUN is ignored.
- Reset is asserted asynchronously at any time and forces reset values immediately. Deassertion is taken synchronously by the standard reset synchronizer upstream.

## Timing
- Request sampled in IDLE at cycle T0:
  - `gnt`/`busy` high from T1 to T(len+1).
  - `cnt` = 0,1,…,len over T1 to T(len+1).
  - `done[i]` high in T(len+2) only, with `busy` still high.
  - IDLE again at T(len+3).
- The next grant is earliest at T(len+4), so there is a mandatory one-cycle IDLE gap between intervals.
- Abort:
  - `abort` high in RUN cycle Tk gives IDLE at Tk+1.
  - `gnt`=0, `busy`=0 and `cnt`=0 at Tk+1.

## Configuration
- `RCC_SCHED_FIXED_PRIO_EN`
  - Defined: fixed priority. The lowest-index asserted `req` always wins, and the pointer logic is removed.
  - Undefined (default): round-robin as described above.

## Test plan
- **Reset:** drive `reset`=0 mid-RUN with `cnt`=2 → `gnt`=0, `done`=0, `busy`=0 and `cnt`=0 immediately (asynchronous); after release, IDLE with the pointer at 0.
- **Single request:** `req`=01, `len0`=3 → `gnt`=01 for 4 cycles with `cnt` 0,1,2,3; `done`=01 for exactly 1 cycle; then IDLE.
- **Contention:** `req`=11 held, `len0`=2, `len1`=1 → grant order 01,10,01,10 with a 1-cycle IDLE gap between intervals. With `RCC_SCHED_FIXED_PRIO_EN` defined → 01,01,01.
- **Zero length:** `len`=0 → `gnt` high 1 cycle with `cnt`=0; `done` pulses the next cycle.
- **Abort:** `abort` at `cnt`=2 of `len`=5 → IDLE the next cycle, no `done`, `cnt`=0. Abort in the same cycle as `cnt`==`term` → no `done`.
- **Maximum length:** `len`=15 → `cnt` reaches 15 without wrapping; `done` follows; 16 RUN cycles total.

Source files
------------

// File: rtl/rcc_sched.sv
// rcc_sched: shares one WIDTH-bit interval counter among NREQ requesters (RR or fixed priority).
// Latency: gnt one cycle after req is seen in IDLE; done len+2 cycles after that; one IDLE cycle between intervals.
// Backpressure: req is a held level with no queueing; losers wait in place until granted; abort cancels RUN.
// Build option: define RCC_SCHED_FIXED_PRIO_EN for fixed lowest-index priority (default is round-robin).
module rcc_sched #(
  parameter int NREQ  = 2,
  parameter int WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] len,
  input  logic                  abort,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic [WIDTH-1:0]      cnt
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_term;
  logic [WIDTH-1:0] r_cnt;
  logic [NREQ-1:0]  r_gnt;
  logic [NREQ-1:0]  r_done;
  logic             r_busy;

  logic             w_any;
  logic [IW-1:0]    w_win;
  logic [NREQ-1:0]  w_win_oh;
  logic [WIDTH-1:0] w_win_len;

`ifdef RCC_SCHED_FIXED_PRIO_EN
  // Lowest asserted index wins; the downward scan leaves the lowest hit in w_win.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        w_any = 1'b1;
        w_win = IW'(i);
      end
    end
  end
`else
  logic [IW-1:0] r_ptr;
  logic          w_hi_any;
  logic [IW-1:0] w_hi_win;
  logic [IW-1:0] w_lo_win;
  logic [IW-1:0] w_ptr_nxt;

  // Round-robin: lowest request at or above the pointer, else wrap to the lowest request overall.
  always_comb begin
    w_any    = 1'b0;
    w_hi_any = 1'b0;
    w_hi_win = '0;
    w_lo_win = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        w_any    = 1'b1;
        w_lo_win = IW'(i);
        if (IW'(i) >= r_ptr) begin
          w_hi_any = 1'b1;
          w_hi_win = IW'(i);
        end
      end
    end
    w_win     = w_hi_any ? w_hi_win : w_lo_win;
    w_ptr_nxt = (w_win == IW'(NREQ - 1)) ? '0 : (w_win + IW'(1));
  end

  // Move the pointer just past each winner so that requester ranks lowest next time.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr <= '0;
    end else if (r_state == S_IDLE && w_any) begin
      r_ptr <= w_ptr_nxt;
    end
  end
`endif

  // Decode the winner into its one-hot grant and pick out its length slice.
  always_comb begin
    w_win_oh  = '0;
    w_win_len = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IW'(i) == w_win) begin
        w_win_oh[i] = 1'b1;
        w_win_len   = len[i*WIDTH +: WIDTH];
      end
    end
  end

  // Interval sequencer: grant in IDLE, count in RUN, pulse done in DONE; every output is a register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_term  <= '0;
      r_cnt   <= '0;
      r_gnt   <= '0;
      r_done  <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= '0;
          if (w_any) begin
            r_term  <= w_win_len;
            r_cnt   <= '0;
            r_gnt   <= w_win_oh;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          // Abort is checked first so it beats a terminal count reached in the same cycle.
          if (abort) begin
            r_gnt   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (r_cnt == r_term) begin
            r_gnt   <= '0;
            r_done  <= r_gnt;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + WIDTH'(1);
          end
        end
        S_DONE: begin
          // Final count is left visible; it is cleared only by the next grant or an abort.
          r_done  <= '0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_gnt   <= '0;
          r_done  <= '0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign gnt  = r_gnt;
  assign done = r_done;
  assign busy = r_busy;
  assign cnt  = r_cnt;

endmodule

// File: tb/tb_rcc_sched.sv
// tb_rcc_sched: random and directed intervals checked against a transaction-level model.
// The driver predicts each interval (owner, length, abort point) into a queue.
// The monitor pops one entry per observed grant and checks the whole interval cycle by cycle.
module tb_rcc_sched;
  localparam int NREQ  = 2;
  localparam int WIDTH = 4;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] len;
  logic                  abort;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic                  busy;
  logic [WIDTH-1:0]      cnt;

  rcc_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .len   (len),
    .abort (abort),
    .gnt   (gnt),
    .done  (done),
    .busy  (busy),
    .cnt   (cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int oh;
    int len;
    int abk;
    bit follow;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_err  = 0;
  int   m_ptr  = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Arbitration rule from the requester's point of view.
  function automatic int model_pick(input logic [1:0] rv);
`ifdef RCC_SCHED_FIXED_PRIO_EN
    for (int i = 0; i < NREQ; i++) if (rv[i]) return i;
    return 0;
`else
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (m_ptr + k) % NREQ;
      if (rv[i]) begin
        m_ptr = (i + 1) % NREQ;
        return i;
      end
    end
    return 0;
`endif
  endfunction

  task automatic wait_evt(input bit for_done, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((for_done ? done : gnt) != '0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: got timeout expected event within 40 cycles", for_done ? "wait_done" : "wait_gnt");
    end
  endtask

  // Predict nint intervals for a held request vector, then drive it (abort only for single intervals).
  task automatic do_trial(input logic [1:0] rv, input logic [3:0] l0, input logic [3:0] l1,
                          input int nint, input int abk);
    exp_t e;
    int   w;
    int   ab;
    bit   ok;
    ab = -1;
    for (int n = 0; n < nint; n++) begin
      w      = model_pick(rv);
      e.oh   = 1 << w;
      e.len  = (w == 0) ? int'(l0) : int'(l1);
      e.abk  = -1;
      if (nint == 1 && abk >= 0) e.abk = (abk > e.len) ? e.len : abk;
      e.follow = (n < nint - 1);
      ab = e.abk;
      exp_q.push_back(e);
    end
    @(negedge clk);
    req = rv;
    len = {l1, l0};
    for (int n = 0; n < nint; n++) begin
      wait_evt(1'b0, ok);
      if (!ok) break;
      if (ab >= 0) begin
        repeat (ab) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        req   = '0;
      end else begin
        wait_evt(1'b1, ok);
        if (!ok) break;
        if (n == nint - 1) req = '0;
      end
    end
    req = '0;
    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Monitor: one expected entry per grant; checks every cycle of the interval and the gap after it.
  initial begin : monitor
    exp_t e;
    int   last;
    bit   must_grant;
    must_grant = 1'b0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        must_grant = 1'b0;
        continue;
      end
      if (gnt == '0) begin
        chk("idle_done", int'(done), 0);
        chk("idle_busy", int'(busy), 0);
        if (must_grant) chk("held_regrant", int'(gnt), (exp_q.size() != 0) ? exp_q[0].oh : 1);
        must_grant = 1'b0;
        continue;
      end
      must_grant = 1'b0;
      if (exp_q.size() == 0) begin
        chk("unexpected_grant", int'(gnt), 0);
        continue;
      end
      e    = exp_q.pop_front();
      last = (e.abk >= 0) ? e.abk : e.len;
      for (int c = 0; c <= last; c++) begin
        if (c > 0) @(negedge clk);
        chk("run_gnt", int'(gnt), e.oh);
        chk("run_cnt", int'(cnt), c);
        chk("run_busy", int'(busy), 1);
        chk("run_done", int'(done), 0);
      end
      @(negedge clk);
      if (e.abk >= 0) begin
        chk("abort_gnt", int'(gnt), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_cnt", int'(cnt), 0);
        chk("abort_done", int'(done), 0);
      end else begin
        chk("done_pulse", int'(done), e.oh);
        chk("done_gnt", int'(gnt), 0);
        chk("done_busy", int'(busy), 1);
        chk("done_cnt", int'(cnt), e.len);
        @(negedge clk);
        chk("gap_done", int'(done), 0);
        chk("gap_gnt", int'(gnt), 0);
        chk("gap_busy", int'(busy), 0);
        chk("gap_cnt", int'(cnt), e.len);
        must_grant = e.follow;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    bit         ok;
    int         nint;
    int         abk;
    logic [1:0] rv;
    logic [3:0] l0;
    logic [3:0] l1;

    reset = 1'b0;
    req   = '0;
    len   = '0;
    abort = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_gnt", int'(gnt), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_cnt", int'(cnt), 0);
    reset = 1'b1;
    @(negedge clk);

    // Asynchronous reset in the middle of an interval at cnt=2.
    req = 2'b01;
    len = {4'd0, 4'd5};
    wait_evt(1'b0, ok);
    repeat (2) @(negedge clk);
    chk("pre_reset_cnt", int'(cnt), 2);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_gnt", int'(gnt), 0);
    chk("async_rst_done", int'(done), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_cnt", int'(cnt), 0);
    req = '0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", int'(busy), 0);
    m_ptr = 0;
    exp_q.delete();
    mon_en = 1'b1;

    // Contention right after reset also shows the pointer restarted at requester 0.
    do_trial(2'b11, 4'd2, 4'd1, 4, -1);
    do_trial(2'b01, 4'd3, 4'd0, 1, -1);
    do_trial(2'b10, 4'd9, 4'd0, 1, -1);
    do_trial(2'b01, 4'd5, 4'd7, 1, 2);
    do_trial(2'b10, 4'd1, 4'd3, 1, 3);
    do_trial(2'b01, 4'd15, 4'd4, 1, -1);
    do_trial(2'b10, 4'd2, 4'd15, 2, -1);

    for (int t = 0; t < 40; t++) begin
      rv   = 2'($urandom_range(1, 3));
      l0   = 4'($urandom_range(0, 15));
      l1   = 4'($urandom_range(0, 15));
      nint = int'($urandom_range(1, 3));
      abk  = -1;
      if (nint == 1 && $urandom_range(0, 2) == 0) abk = int'($urandom_range(0, 15));
      do_trial(rv, l0, l1, nint, abk);
      // Abort outside RUN must be ignored.
      if ($urandom_range(0, 1) == 1) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
      end
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
